// File: rtl/offset_pipe_pkg.sv
// -----------------------------------------------------------------------------
// offset_pipe_pkg
// Shared constants and helpers for the offset_pipe datapath.
//   - DEF_WIDTH / DEF_STAGES / DEF_RST_OFFSET : default parameter values
//   - occ_width(stages) : width of an occupancy count able to hold 0..stages
//   - add_off(a, b, w)  : w-bit offset add on zero-extended operands (w <= 64).
//                         Wraps modulo 2^w. With OFFSET_PIPE_SAT_EN defined it
//                         saturates to all-ones on carry-out instead.
// -----------------------------------------------------------------------------
package offset_pipe_pkg;

    localparam int         DEF_WIDTH      = 8;
    localparam int         DEF_STAGES     = 2;
    localparam logic [7:0] DEF_RST_OFFSET = 8'h10;
    localparam int         ADD_MAX_W      = 64;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

    function automatic logic [ADD_MAX_W-1:0] add_off(
        input logic [ADD_MAX_W-1:0] a,
        input logic [ADD_MAX_W-1:0] b,
        input int                   w
    );
        logic [ADD_MAX_W-1:0] mask;
        mask = {ADD_MAX_W{1'b1}} >> (ADD_MAX_W - w);
`ifdef OFFSET_PIPE_SAT_EN
        // a + b overflows w bits exactly when a exceeds (2^w - 1) - b.
        if (a > (mask & ~b)) begin
            return mask;
        end
`endif
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/offset_pipe_stage.sv
// -----------------------------------------------------------------------------
// offset_pipe_stage
// One valid/ready register slice. Accepts a new item whenever it is empty or
// the downstream slice is taking the current one, so a chain of these runs at
// full throughput without bubbles.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   up_valid, up_data   : item offered by the upstream side
//   dn_ready            : downstream side takes the held item this cycle
//   valid, data         : held item
//   ready               : slice loads this cycle (!valid || dn_ready)
// -----------------------------------------------------------------------------
module offset_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    assign ready = !valid || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ready) begin
            valid <= up_valid;
            // Data only moves with a real item, keeping empty slices quiet.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/offset_pipe.sv
// -----------------------------------------------------------------------------
// offset_pipe
// STAGES-deep valid/ready pipeline carrying WIDTH-bit samples; the final stage
// adds a runtime-programmable offset. Counts delivered items.
// Optional build macro: OFFSET_PIPE_SAT_EN -- saturating final add plus a
// sticky sat_flag output set when a saturated result is delivered.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_valid, in_ready, in_data  : producer side (in_ready is combinational)
//   out_valid, out_ready, out_data : consumer side, out_data = sample + offset
//   cfg_we, cfg_offset           : offset register write
//   offset_o                     : current offset register
//   occupancy                    : number of valid stages
//   sat_flag                     : (OFFSET_PIPE_SAT_EN only) sticky saturation
//   item_cnt                     : delivered items, wrapping
// -----------------------------------------------------------------------------
module offset_pipe
    import offset_pipe_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               STAGES     = DEF_STAGES,
    parameter logic [WIDTH-1:0] RST_OFFSET = WIDTH'(DEF_RST_OFFSET),
    parameter int               CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    input  logic                           cfg_we,
    input  logic [WIDTH-1:0]               cfg_offset,
    output logic [WIDTH-1:0]               offset_o,
    output logic [occ_width(STAGES)-1:0]   occupancy,
`ifdef OFFSET_PIPE_SAT_EN
    output logic                           sat_flag,
`endif
    output logic [CNT_W-1:0]               item_cnt
);

    localparam int OCC_W = occ_width(STAGES);

    logic             valid_s [STAGES];
    logic [WIDTH-1:0] data_s  [STAGES];
    logic             ready_s [STAGES+1];
    logic [WIDTH-1:0] offset_q;
    logic             push;
    logic             pop;

`ifdef OFFSET_PIPE_SAT_EN
    logic             src_last_v;
    logic [WIDTH-1:0] src_last;
    logic             sat_q;
`endif

    assign ready_s[STAGES] = out_ready;
    assign in_ready        = ready_s[0];
    assign out_valid       = valid_s[STAGES-1];
    assign out_data        = data_s[STAGES-1];
    assign offset_o        = offset_q;
    assign push            = in_valid && in_ready;
    assign pop             = out_valid && out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        logic [WIDTH-1:0] load_d;

        if (i == 0) begin : g_head
            assign src_v = in_valid;
            assign src_d = in_data;
        end else begin : g_body
            assign src_v = valid_s[i-1];
            assign src_d = data_s[i-1];
        end

        // The final slice takes the offset sum; offset_q is the pre-write value
        // on a cfg_we edge, so an item entering on that edge sees the old offset.
        if (i == STAGES - 1) begin : g_tail
            assign load_d = WIDTH'(add_off(ADD_MAX_W'(src_d), ADD_MAX_W'(offset_q), WIDTH));
`ifdef OFFSET_PIPE_SAT_EN
            assign src_last_v = src_v;
            assign src_last   = src_d;
`endif
        end else begin : g_pass
            assign load_d = src_d;
        end

        offset_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (src_v),
            .up_data  (load_d),
            .dn_ready (ready_s[i+1]),
            .valid    (valid_s[i]),
            .data     (data_s[i]),
            .ready    (ready_s[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q  <= RST_OFFSET;
            occupancy <= '0;
            item_cnt  <= '0;
        end else begin
            if (cfg_we) begin
                offset_q <= cfg_offset;
            end
            // Valid-bit count changes by exactly one per accepted or delivered item.
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
            if (pop) begin
                item_cnt <= item_cnt + 1'b1;
            end
        end
    end

`ifdef OFFSET_PIPE_SAT_EN
    // sat_q tracks whether the item held in the final slice was clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q    <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (ready_s[STAGES-1] && src_last_v) begin
                sat_q <= (src_last > ~offset_q);
            end
            if (pop && sat_q) begin
                sat_flag <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_offset_pipe.sv
module tb_offset_pipe;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             cfg_we;
    logic [W-1:0]     cfg_offset;
    logic [W-1:0]     offset_o;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] item_cnt;
`ifdef OFFSET_PIPE_SAT_EN
    logic             sat_flag;
`endif

    offset_pipe #(
        .WIDTH  (W),
        .STAGES (2),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_offset (cfg_offset),
        .offset_o   (offset_o),
        .occupancy  (occupancy),
`ifdef OFFSET_PIPE_SAT_EN
        .sat_flag   (sat_flag),
`endif
        .item_cnt   (item_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] off;
        logic [W-1:0] din;
        logic [W-1:0] exp_wrap;
        logic [W-1:0] exp_sat;
    } vec_t;

    vec_t             vecs [8];
    logic [CNT_W-1:0] exp_cnt;
    int               p;
    int               got;
    logic             hs_in;
    logic             hs_out;
    logic             full_pp;

    initial begin
        vecs[0] = '{off: 8'h10, din: 8'h00, exp_wrap: 8'h10, exp_sat: 8'h10};
        vecs[1] = '{off: 8'h10, din: 8'hF8, exp_wrap: 8'h08, exp_sat: 8'hFF};
        vecs[2] = '{off: 8'h10, din: 8'hEF, exp_wrap: 8'hFF, exp_sat: 8'hFF};
        vecs[3] = '{off: 8'h10, din: 8'hF0, exp_wrap: 8'h00, exp_sat: 8'hFF};
        vecs[4] = '{off: 8'h7F, din: 8'h80, exp_wrap: 8'hFF, exp_sat: 8'hFF};
        vecs[5] = '{off: 8'h01, din: 8'hFF, exp_wrap: 8'h00, exp_sat: 8'hFF};
        vecs[6] = '{off: 8'h00, din: 8'hAB, exp_wrap: 8'hAB, exp_sat: 8'hAB};
        vecs[7] = '{off: 8'hFF, din: 8'h01, exp_wrap: 8'h00, exp_sat: 8'hFF};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        cfg_we     = 1'b0;
        cfg_offset = '0;
        exp_cnt    = '0;
        full_pp    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_item_cnt", item_cnt, 0);
        chk("rst_offset", offset_o, 8'h10);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
`ifdef OFFSET_PIPE_SAT_EN
        chk("rst_sat_flag", sat_flag, 0);
`endif

        // Single item: accepted at edge t, visible after edge t+1
        in_valid  = 1'b1;
        in_data   = 8'h05;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_lat1_valid", out_valid, 0);
        chk("single_occ1", occupancy, 1);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'h15);
        exp_cnt++;
        tick();
        chk("single_cnt", item_cnt, exp_cnt);
        chk("single_drained", out_valid, 0);

        // Table: offset / data combinations through an idle pipe
        for (int k = 0; k < 8; k++) begin
            cfg_we     = 1'b1;
            cfg_offset = vecs[k].off;
            tick();
            cfg_we = 1'b0;
            chk($sformatf("vec%0d_offset", k), offset_o, vecs[k].off);
            in_valid  = 1'b1;
            in_data   = vecs[k].din;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("vec%0d_valid", k), out_valid, 1);
`ifdef OFFSET_PIPE_SAT_EN
            chk($sformatf("vec%0d_data", k), out_data, vecs[k].exp_sat);
`else
            chk($sformatf("vec%0d_data", k), out_data, vecs[k].exp_wrap);
`endif
            exp_cnt++;
            tick();
        end
        chk("vec_cnt", item_cnt, exp_cnt);
`ifdef OFFSET_PIPE_SAT_EN
        chk("vec_sat_flag", sat_flag, 1);
`endif
        cfg_we     = 1'b1;
        cfg_offset = 8'h10;
        tick();
        cfg_we = 1'b0;

        // Backpressure: stream 0..7, consumer stalled for the first 5 cycles
        p   = 0;
        got = 0;
        for (int c = 0; c < 40 && !(p == 8 && got == 8); c++) begin
            in_valid  = (p < 8);
            in_data   = W'(p);
            out_ready = (c >= 5);
            #1;
            if (!out_ready && occupancy == 2) chk("bp_full_in_ready", in_ready, 0);
            if (!out_ready && out_valid) chk("bp_hold_data", out_data, 8'h10);
            if (out_ready && occupancy == 2 && in_valid) begin
                chk("bp_pushpop_in_ready", in_ready, 1);
                full_pp = 1'b1;
            end else begin
                full_pp = 1'b0;
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                chk($sformatf("bp_out%0d", got), out_data, 32'h10 + 32'(got));
                got++;
                exp_cnt++;
            end
            tick();
            if (hs_in) p++;
            if (full_pp && hs_in && hs_out) chk("bp_pushpop_occ", occupancy, 2);
        end
        chk("bp_done", (p == 8 && got == 8), 1);
        in_valid = 1'b0;
        tick();
        chk("bp_cnt_wrapped", item_cnt, exp_cnt);
        chk("bp_empty", occupancy, 0);

        // Offset change on the edge where item 0x01 enters the final stage
        in_valid  = 1'b1;
        in_data   = 8'h01;
        out_ready = 1'b1;
        tick();
        cfg_we     = 1'b1;
        cfg_offset = 8'h20;
        in_data    = 8'h02;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        chk("ofs_old_valid", out_valid, 1);
        chk("ofs_old_data", out_data, 8'h11);
        chk("ofs_reg", offset_o, 8'h20);
        exp_cnt++;
        tick();
        chk("ofs_new_valid", out_valid, 1);
        chk("ofs_new_data", out_data, 8'h22);
        exp_cnt++;
        tick();
        chk("ofs_cnt", item_cnt, exp_cnt);
        chk("ofs_drained", out_valid, 0);

        // Mid-stream asynchronous reset with a full pipe
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h30;
        tick();
        in_data = 8'h31;
        tick();
        in_valid = 1'b0;
        chk("mrst_full_occ", occupancy, 2);
        chk("mrst_full_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_async_valid", out_valid, 0);
        chk("mrst_async_occ", occupancy, 0);
        chk("mrst_async_offset", offset_o, 8'h10);
        chk("mrst_async_cnt", item_cnt, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("mrst_no_stale%0d", c), out_valid, 0);
        end
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_offset", offset_o, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
